// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: the pipeline drives the hazard inputs (master),
// and the controller returns the pipeline-register gating (slave).
interface hazard_ctrl_if;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_md;
  logic        ex_mem_read;
  logic [2:0]  ex_wr_reg;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_flush;
  logic        exmem_bubble;
  logic        md_go;
  logic        busy;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md,
           ex_mem_read, ex_wr_reg, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_bubble, md_go, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_md,
           ex_mem_read, ex_wr_reg, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_bubble, md_go, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch squash and multicycle md hold.
// Optional stall/flush statistics counters are built when HAZ_STATS_EN is defined.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lu;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_write;
  logic             w_idex_flush;
  logic             w_exmem_bubble;
  logic             w_md_go;
  logic             w_busy;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_lu = hz.ex_mem_read && (hz.ex_wr_reg != 3'd0) &&
                ((hz.id_uses_rs && (hz.id_rs == hz.ex_wr_reg)) ||
                 (hz.id_uses_rt && (hz.id_rt == hz.ex_wr_reg)));

  // State register and md down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_write     = 1'b0;
    w_ifid_write   = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_write   = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_bubble = 1'b0;
    w_md_go        = 1'b0;
    w_busy         = 1'b0;
    if (rst) begin
      w_ifid_flush   = 1'b1;
      w_idex_write   = 1'b1;
      w_idex_flush   = 1'b1;
      w_exmem_bubble = 1'b1;
      w_state_nxt    = RUN;
      w_cnt_nxt      = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_write = 1'b1;
            w_idex_flush = 1'b1;
          end else if (w_lu) begin
            w_idex_write = 1'b1;
            w_idex_flush = 1'b1;
          end else if (hz.id_is_md) begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_idex_write = 1'b1;
            w_md_go      = 1'b1;
            w_state_nxt  = MD_BUSY;
            w_cnt_nxt    = CNT_W'(MD_CYCLES - 1);
          end else begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_idex_write = 1'b1;
          end
        end
        MD_BUSY: begin
          w_busy    = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          // Last busy cycle: the md result is allowed into EX/MEM
          if (r_cnt == CNT_W'(1)) begin
            w_exmem_bubble = 1'b0;
            w_state_nxt    = RUN;
            w_cnt_nxt      = {CNT_W{1'b0}};
          end else begin
            w_exmem_bubble = 1'b1;
          end
        end
        default: begin
          w_ifid_flush   = 1'b1;
          w_idex_write   = 1'b1;
          w_idex_flush   = 1'b1;
          w_exmem_bubble = 1'b1;
          w_state_nxt    = RUN;
          w_cnt_nxt      = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign hz.pc_write     = w_pc_write;
  assign hz.ifid_write   = w_ifid_write;
  assign hz.ifid_flush   = w_ifid_flush;
  assign hz.idex_write   = w_idex_write;
  assign hz.idex_flush   = w_idex_flush;
  assign hz.exmem_bubble = w_exmem_bubble;
  assign hz.md_go        = w_md_go;
  assign hz.busy         = w_busy;

`ifdef HAZ_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if ((r_state == RUN) && hz.ex_branch_taken && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'h0001;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = 16'h0000;
  assign hz.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand-written md/reset sequences,
// and random stimulus against a counter-of-remaining-busy-cycles reference model.
module tb_hazard_ctrl;
  localparam int MDC = 4;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       md;
    logic       mr;
    logic [2:0] wr;
    logic       br;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  // output vector order: pc_write ifid_write ifid_flush idex_write idex_flush exmem_bubble md_go busy
  localparam logic [7:0] O_RST   = 8'b0011_1100;
  localparam logic [7:0] O_NORM  = 8'b1101_0000;
  localparam logic [7:0] O_BR    = 8'b1111_1000;
  localparam logic [7:0] O_STALL = 8'b0001_1000;
  localparam logic [7:0] O_MDGO  = 8'b1101_0010;
  localparam logic [7:0] O_BUSY  = 8'b0000_0101;
  localparam logic [7:0] O_BLAST = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   md_left = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic r, input logic [2:0] rs, input logic [2:0] rt,
                               input logic urs, input logic urt, input logic md,
                               input logic mr, input logic [2:0] wr, input logic br);
    stim_t s;
    s.rst = r; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.md = md; s.mr = mr; s.wr = wr; s.br = br;
    return s;
  endfunction

  function automatic logic [7:0] model_out(input stim_t s, input int left);
    bit lu;
    lu = s.mr && (s.wr != 3'd0) && ((s.urs && s.rs == s.wr) || (s.urt && s.rt == s.wr));
    if (s.rst) return O_RST;
    if (left > 0) return (left == 1) ? O_BLAST : O_BUSY;
    if (s.br) return O_BR;
    if (lu) return O_STALL;
    if (s.md) return O_MDGO;
    return O_NORM;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // One cycle: drive at negedge, compare combinational outputs, advance model at posedge.
  task automatic apply(input stim_t s, input logic [7:0] exp, input string nm);
    logic [7:0] got;
    logic [7:0] mo;
    @(negedge clk);
    rst                   = s.rst;
    hz_if.id_rs           = s.rs;
    hz_if.id_rt           = s.rt;
    hz_if.id_uses_rs      = s.urs;
    hz_if.id_uses_rt      = s.urt;
    hz_if.id_is_md        = s.md;
    hz_if.ex_mem_read     = s.mr;
    hz_if.ex_wr_reg       = s.wr;
    hz_if.ex_branch_taken = s.br;
    #1;
    got = {hz_if.pc_write, hz_if.ifid_write, hz_if.ifid_flush, hz_if.idex_write,
           hz_if.idex_flush, hz_if.exmem_bubble, hz_if.md_go, hz_if.busy};
    check(nm, {24'd0, got}, {24'd0, exp});
    if (s.br && hz_if.busy) check("br_in_busy", 32'd1, 32'd0);
    mo = model_out(s, md_left);
    if (s.rst) begin
      md_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!mo[7] && m_stall < 65535) m_stall++;
      if (md_left == 0 && s.br && m_flush < 65535) m_flush++;
      if (md_left > 0) md_left--;
      else if (mo[1]) md_left = MDC - 1;
    end
    @(posedge clk);
  endtask

  task automatic check_stats(input string nm, input int exp_s, input int exp_f);
    #1;
`ifdef HAZ_STATS_EN
    check({nm, "_stall"}, {16'd0, hz_if.stall_cnt}, exp_s);
    check({nm, "_flush"}, {16'd0, hz_if.flush_cnt}, exp_f);
`else
    check({nm, "_stall"}, {16'd0, hz_if.stall_cnt}, 32'd0);
    check({nm, "_flush"}, {16'd0, hz_if.flush_cnt}, 32'd0);
    if (exp_s < 0 || exp_f < 0) check({nm, "_neg"}, 32'd1, 32'd0);
`endif
  endtask

  vec_t  tbl[11];
  stim_t idle;
  stim_t rs_s;
  stim_t md_s;
  stim_t lu_s;
  stim_t br_s;
  stim_t rnd;

  initial begin
    idle = mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    rs_s = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    md_s = mk(1'b0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    lu_s = mk(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    br_s = mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    tbl[0]  = '{mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0), O_NORM,  "idle"};
    tbl[1]  = '{mk(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0), O_STALL, "lu_rs"};
    tbl[2]  = '{mk(1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0), O_NORM,  "lu_r0"};
    tbl[3]  = '{mk(1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0), O_NORM,  "rs_unused"};
    tbl[4]  = '{mk(1'b0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0), O_STALL, "lu_rt"};
    tbl[5]  = '{mk(1'b0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1), O_BR,    "br_over_lu"};
    tbl[6]  = '{mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1), O_BR,    "br_over_md"};
    tbl[7]  = '{mk(1'b0, 3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0), O_STALL, "lu_over_md"};
    tbl[8]  = '{mk(1'b0, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0), O_NORM,  "no_load"};
    tbl[9]  = '{mk(1'b0, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0), O_NORM,  "no_match"};
    tbl[10] = '{mk(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1), O_RST,   "rst_dominant"};

    apply(rs_s, O_RST, "reset0");
    apply(rs_s, O_RST, "reset1");
    for (int i = 0; i < 3; i++) apply(idle, O_NORM, "post_reset_run");

    for (int i = 0; i < 11; i++) apply(tbl[i].s, tbl[i].exp, tbl[i].nm);

    // md op: one go pulse, three busy cycles, then back to RUN
    apply(idle, O_NORM, "pre_md");
    apply(md_s, O_MDGO, "md_go");
    apply(br_s & ~br_s | lu_s, O_BUSY, "md_busy1_lu_ignored");
    apply(md_s, O_BUSY, "md_busy2");
    apply(idle, O_BLAST, "md_busy3");
    // back-to-back md op restarts with no gap
    apply(md_s, O_MDGO, "md_b2b_go");
    apply(idle, O_BUSY, "md_b2b_busy1");
    apply(idle, O_BUSY, "md_b2b_busy2");
    apply(idle, O_BLAST, "md_b2b_busy3");
    apply(idle, O_NORM, "md_done");

    // reset on the 2nd busy cycle aborts the op
    apply(md_s, O_MDGO, "abort_go");
    apply(idle, O_BUSY, "abort_busy1");
    apply(rs_s, O_RST, "abort_rst");
    apply(idle, O_NORM, "abort_run");
    apply(md_s, O_MDGO, "abort_cnt_fresh");
    apply(idle, O_BUSY, "abort_cnt_b1");
    apply(idle, O_BUSY, "abort_cnt_b2");
    apply(idle, O_BLAST, "abort_cnt_b3");

    // statistics: 2 load-use stalls, 1 md op, 2 taken branches
    apply(rs_s, O_RST, "stats_rst");
    check_stats("stats_clear", 0, 0);
    apply(lu_s, O_STALL, "stats_lu1");
    apply(idle, O_NORM, "stats_n1");
    apply(lu_s, O_STALL, "stats_lu2");
    apply(md_s, O_MDGO, "stats_md");
    apply(idle, O_BUSY, "stats_b1");
    apply(idle, O_BUSY, "stats_b2");
    apply(idle, O_BLAST, "stats_b3");
    apply(br_s, O_BR, "stats_br1");
    apply(idle, O_NORM, "stats_n2");
    apply(br_s, O_BR, "stats_br2");
    check_stats("stats_total", 5, 2);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rnd.rst = ($urandom_range(0, 99) == 0);
      rnd.rs  = 3'($urandom_range(0, 7));
      rnd.rt  = 3'($urandom_range(0, 7));
      rnd.urs = 1'($urandom_range(0, 1));
      rnd.urt = 1'($urandom_range(0, 1));
      rnd.md  = ($urandom_range(0, 5) == 0);
      rnd.mr  = 1'($urandom_range(0, 1));
      rnd.wr  = 3'($urandom_range(0, 7));
      rnd.br  = (md_left == 0) && ($urandom_range(0, 7) == 0);
      apply(rnd, model_out(rnd, md_left), "random");
      check_stats("random", m_stall, m_flush);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
